// File: rtl/qoa_slice_decoder.sv
// qoa_slice_decoder
//   Byte-serial QOA record decoder. Accepts 16-byte LMS state loads and
//   8-byte slices (big-endian). Each slice yields 20 reconstructed signed
//   16-bit samples using a per-channel 4-tap LMS predictor.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data/valid/ready  record byte stream
//   in_mode              0 = slice record, 1 = LMS record (first byte only)
//   in_chan              target channel (first byte only)
//   out_sample/chan      reconstructed sample and its channel
//   out_valid/ready      sample handshake
//   busy                 high whenever the FSM is not idle
module qoa_slice_decoder #(
    parameter int CHANNELS = 1,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic [CH_W-1:0] in_chan,
    output logic [15:0]     out_sample,
    output logic [CH_W-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, COLLECT, PRED, RECON, OUT} state_t;

    state_t state, state_nx;

    logic [119:0]      sh;        // earlier bytes of the current record
    logic [127:0]      rec;       // record including the byte on the bus
    logic [3:0]        bcnt;
    logic [CH_W-1:0]   chan_r;
    logic [3:0]        sf;
    logic [59:0]       res;       // current residual always in [59:57]
    logic [1:0]        pcnt;
    logic [4:0]        scnt;
    logic signed [31:0] acc;

    logic signed [15:0] hist [CHANNELS][4];
    logic signed [31:0] wts  [CHANNELS][4];

    logic               xfer, out_hs, chan_ok;
    logic               last_load, last_coll;
    logic [IDX_W-1:0]   ci;
    logic [3:0][15:0]   rom_row;
    logic signed [15:0] dq;
    logic signed [31:0] pred, sum, delta;
    logic signed [15:0] recon;

    assign xfer    = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign chan_ok = int'(chan_r) < CHANNELS;
    assign ci      = chan_ok ? chan_r[IDX_W-1:0] : '0;
    assign rec     = {sh, in_data};

    assign last_load = (state == LOAD)    && xfer && (bcnt == 4'd15);
    assign last_coll = (state == COLLECT) && xfer && (bcnt == 4'd7);

    // Dequantisation magnitudes; element 0..3 = |M| of 0.75, 2.5, 4.5, 7.
    always_comb begin
        case (sf)
            4'd0:    rom_row = {16'd7,     16'd5,    16'd3,    16'd1};
            4'd1:    rom_row = {16'd49,    16'd32,   16'd18,   16'd5};
            4'd2:    rom_row = {16'd147,   16'd95,   16'd53,   16'd16};
            4'd3:    rom_row = {16'd315,   16'd203,  16'd113,  16'd34};
            4'd4:    rom_row = {16'd588,   16'd378,  16'd210,  16'd63};
            4'd5:    rom_row = {16'd966,   16'd621,  16'd345,  16'd104};
            4'd6:    rom_row = {16'd1477,  16'd950,  16'd528,  16'd158};
            4'd7:    rom_row = {16'd2128,  16'd1368, 16'd760,  16'd228};
            4'd8:    rom_row = {16'd2947,  16'd1895, 16'd1053, 16'd316};
            4'd9:    rom_row = {16'd3934,  16'd2529, 16'd1405, 16'd422};
            4'd10:   rom_row = {16'd5117,  16'd3290, 16'd1828, 16'd548};
            4'd11:   rom_row = {16'd6496,  16'd4176, 16'd2320, 16'd696};
            4'd12:   rom_row = {16'd8099,  16'd5207, 16'd2893, 16'd868};
            4'd13:   rom_row = {16'd9933,  16'd6386, 16'd3548, 16'd1064};
            4'd14:   rom_row = {16'd12005, 16'd7718, 16'd4288, 16'd1286};
            default: rom_row = {16'd14336, 16'd9216, 16'd5120, 16'd1536};
        endcase
    end

    // Odd residual codes are the negated magnitudes.
    assign dq    = res[57] ? -$signed(rom_row[res[59:58]]) : $signed(rom_row[res[59:58]]);
    assign pred  = acc >>> 13;
    assign sum   = pred + 32'(dq);
    assign delta = 32'(dq) >>> 4;

    always_comb begin
        if (sum > 32'sd32767)
            recon = 16'sh7FFF;
        else if (sum < -32'sd32768)
            recon = 16'sh8000;
        else
            recon = sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (xfer)
                    state_nx = in_mode ? LOAD : COLLECT;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (xfer && bcnt == 4'd15)
                    state_nx = IDLE;
            end
            COLLECT: begin
                in_ready = 1'b1;
                // Slices for a nonexistent channel are swallowed silently.
                if (xfer && bcnt == 4'd7)
                    state_nx = chan_ok ? PRED : IDLE;
            end
            PRED: begin
                if (pcnt == 2'd3)
                    state_nx = RECON;
            end
            RECON: state_nx = OUT;
            OUT: begin
                if (out_hs)
                    state_nx = (scnt == 5'd19) ? IDLE : PRED;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh         <= '0;
            bcnt       <= '0;
            chan_r     <= '0;
            sf         <= '0;
            res        <= '0;
            pcnt       <= '0;
            scnt       <= '0;
            acc        <= '0;
            out_sample <= '0;
            out_chan   <= '0;
            out_valid  <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    hist[c][i] <= '0;
                    wts[c][i]  <= '0;
                end
            end
        end else begin
            if (xfer) begin
                sh   <= {sh[111:0], in_data};
                bcnt <= (state == IDLE) ? 4'd1 : bcnt + 4'd1;
            end
            if (state == IDLE && xfer)
                chan_r <= in_chan;

            if (last_load && chan_ok) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    hist[ci][i] <= rec[127 - 16*i -: 16];
                    wts[ci][i]  <= {{16{rec[63 - 16*i]}}, rec[63 - 16*i -: 16]};
                end
            end

            if (last_coll) begin
                sf   <= rec[63:60];
                res  <= rec[59:0];
                scnt <= '0;
                pcnt <= '0;
                acc  <= '0;
            end

            if (state == PRED) begin
                acc  <= acc + 32'(hist[ci][pcnt]) * wts[ci][pcnt];
                pcnt <= pcnt + 2'd1;
            end

            if (state == RECON) begin
                out_sample <= recon;
                out_chan   <= chan_r;
                out_valid  <= 1'b1;
            end

            if (state == OUT && out_hs) begin
                out_valid <= 1'b0;
                for (int unsigned i = 0; i < 4; i++)
                    wts[ci][i] <= wts[ci][i] + (hist[ci][i][15] ? -delta : delta);
                for (int unsigned i = 0; i < 3; i++)
                    hist[ci][i] <= hist[ci][i + 1];
                hist[ci][3] <= out_sample;
                res  <= {res[56:0], 3'b000};
                scnt <= scnt + 5'd1;
                acc  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_qoa_slice_decoder.sv
// tb_qoa_slice_decoder
//   Scoreboard bench for qoa_slice_decoder at CHANNELS=2 with a 2-bit
//   channel index so an out-of-range channel (3) can be addressed.
module tb_qoa_slice_decoder;

    localparam int CHN = 2;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [CW-1:0] in_chan;
    logic [15:0]   out_sample;
    logic [CW-1:0] out_chan;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    qoa_slice_decoder #(.CHANNELS(CHN), .CH_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_chan    (in_chan),
        .out_sample (out_sample),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int ch;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    bit   rand_rdy = 0;

    int m_hist [CHN][4];
    int m_wts  [CHN][4];

    int S_TAB  [16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419, 1715, 2048};
    // M scaled by 4 so rounding can be done in integers.
    int M4_TAB [8]  = '{3, -3, 10, -10, 18, -18, 28, -28};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CHN; c++)
            for (int i = 0; i < 4; i++) begin
                m_hist[c][i] = 0;
                m_wts[c][i]  = 0;
            end
    endtask

    task automatic model_slice(input int ch, input logic [63:0] w);
        int   sf, r, v, mag, dq, acc, pred, s, delta;
        exp_t e;
        sf = int'(w[63:60]);
        for (int k = 0; k < 20; k++) begin
            r   = int'((w >> (57 - 3*k)) & 64'd7);
            v   = S_TAB[sf] * M4_TAB[r];
            mag = ((v < 0 ? -v : v) + 2) / 4;
            dq  = (v < 0) ? -mag : mag;
            acc = 0;
            for (int i = 0; i < 4; i++)
                acc += int'(longint'(m_hist[ch][i]) * longint'(m_wts[ch][i]));
            pred = acc >>> 13;
            s = pred + dq;
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            e.s  = s;
            e.ch = ch;
            sb.push_back(e);
            delta = dq >>> 4;
            for (int i = 0; i < 4; i++)
                m_wts[ch][i] += (m_hist[ch][i] < 0) ? -delta : delta;
            for (int i = 0; i < 3; i++)
                m_hist[ch][i] = m_hist[ch][i + 1];
            m_hist[ch][3] = s;
        end
    endtask

    // Monitor: a sample leaves the DUT on each posedge where valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_sample: got %0d on chan %0d, expected none",
                         $signed(out_sample), out_chan);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sample", int'($signed(out_sample)), e.s);
                check("out_chan", int'(out_chan), e.ch);
            end
            n_out++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy)
            out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic md, input int ch);
        bit ok;
        int guard;
        ok = 0;
        guard = 0;
        in_data  = b;
        in_mode  = md;
        in_chan  = CW'(ch);
        in_valid = 1'b1;
        while (!ok && guard < 3000) begin
            @(negedge clk);
            ok = in_ready;
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got no byte transfer, expected one within 3000 cycles");
        end
    endtask

    task automatic send_lms(input int ch, input int h [4], input int w [4]);
        logic [15:0] t;
        for (int i = 0; i < 4; i++) begin
            t = 16'(h[i]);
            send_byte(t[15:8], 1'b1, ch);
            send_byte(t[7:0], 1'b1, ch);
            if (ch < CHN) m_hist[ch][i] = int'($signed(t));
        end
        for (int i = 0; i < 4; i++) begin
            t = 16'(w[i]);
            send_byte(t[15:8], 1'b1, ch);
            send_byte(t[7:0], 1'b1, ch);
            if (ch < CHN) m_wts[ch][i] = int'($signed(t));
        end
    endtask

    task automatic send_slice(input int ch, input logic [63:0] w);
        if (ch < CHN) model_slice(ch, w);
        for (int j = 0; j < 8; j++)
            send_byte(w[63 - 8*j -: 8], 1'b0, ch);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 5000) begin
            step();
            guard++;
        end
        check("drain_done", int'(sb.size() == 0 && !busy), 1);
    endtask

    // Edges until out_valid is seen, sampled #1 after each posedge.
    task automatic latency(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_outs(input int target);
        int guard;
        guard = 0;
        while (n_out < target && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("wait_outs", n_out, target);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_lms(output int h [4], output int w [4]);
        for (int i = 0; i < 4; i++) begin
            h[i] = int'($urandom_range(0, 65535)) - 32768;
            w[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, bad_stab, bad_rdy, s0, h [4], w [4];
        logic [63:0] word;

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_chan   = '0;
        out_ready = 1'b1;
        model_clear();
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_out_chan", int'(out_chan), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero-state slice: twenty +1 samples.
        send_slice(0, 64'h0);
        check("busy_after_slice", int'(busy), 1);
        latency(n);
        check("zero_latency", n, 5);
        drain();

        // Max scalefactor from reset: 1536, 1554, ...
        do_reset();
        send_slice(0, 64'hF000_0000_0000_0000);
        latency(n);
        check("max_sf_latency", n, 5);
        drain();

        // Positive and negative clamp.
        do_reset();
        h = '{32767, 32767, 32767, 32767};
        w = '{8192, 8192, 8192, 8192};
        send_lms(0, h, w);
        send_slice(0, 64'hF000_0000_0000_0000);
        drain();
        do_reset();
        h = '{-32768, -32768, -32768, -32768};
        send_lms(0, h, w);
        send_slice(0, 64'hF200_0000_0000_0000);
        drain();

        // Backpressure at sample 3.
        do_reset();
        base = n_out;
        send_slice(0, {$urandom, $urandom});
        wait_outs(base + 3);
        out_ready = 1'b0;
        latency(n);
        check("bp_sample3_latency", n, 5);
        s0 = int'(out_sample);
        bad_stab = 0;
        bad_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || int'(out_sample) != s0) bad_stab++;
            if (in_ready) bad_rdy++;
        end
        check("bp_stable_cycles", bad_stab, 0);
        check("bp_in_ready_low", bad_rdy, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", int'(out_valid), 0);
        latency(n);
        check("bp_sample4_latency", n, 5);
        drain();

        // Multi-channel: load ch1, slice ch0, slice ch1, then ch3 ignored.
        do_reset();
        rand_lms(h, w);
        send_lms(1, h, w);
        send_slice(0, {$urandom, $urandom});
        send_slice(1, {$urandom, $urandom});
        drain();
        base = n_out;
        rand_lms(h, w);
        send_lms(3, h, w);
        send_slice(3, {$urandom, $urandom});
        repeat (40) @(posedge clk);
        #1;
        check("ch3_no_output", n_out - base, 0);
        check("ch3_idle", int'(busy), 0);
        send_slice(1, {$urandom, $urandom});
        drain();

        // Random records with random backpressure.
        rand_rdy = 1;
        for (int r = 0; r < 10; r++) begin
            int ch;
            ch = ($urandom_range(0, 3) == 0) ? 3 : int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                rand_lms(h, w);
                send_lms(ch, h, w);
            end else begin
                word = {$urandom, $urandom};
                send_slice(ch, word);
            end
        end
        drain();
        rand_rdy = 0;
        out_ready = 1'b1;

        // Reset mid-slice after sample 7, then LMS state must be zero.
        rand_lms(h, w);
        send_lms(0, h, w);
        base = n_out;
        send_slice(0, {$urandom, $urandom});
        wait_outs(base + 8);
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_slice(0, 64'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qoa_slice_decoder.md
# qoa_slice_decoder

Streaming QOA slice decoder with per-channel LMS predictor state, parametrised in channel count. It accepts byte-serial QOA records: either 16-byte LMS state loads or 8-byte slices. For each slice it emits 20 reconstructed signed 16-bit PCM samples through a valid/ready handshake. It sits between the byte-input pins and the sample output path of the top-level decoder and replaces the earlier single-purpose arithmetic stub.

## Interface
- CHANNELS, 1: number of independent LMS state sets (1..8).
- CH_W, $clog2(CHANNELS) min 1: channel index width.

Ports:
- clk  in  1  clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  record byte, big-endian.
- in_valid  in  1  byte present.
- in_ready  out  1  block accepts a byte.
- in_mode  in  1  0 = slice record, 1 = LMS record; sampled with the first byte of a record.
- in_chan  in  CH_W  target channel; sampled with the first byte of a record.
- out_sample  out  16  reconstructed sample, two's complement.
- out_chan  out  CH_W  channel of out_sample.
- out_valid  out  1  sample present.
- out_ready  in  1  sink accepts the sample.
- busy  out  1  high in any state other than IDLE.

## Operation
- A byte transfers when in_valid and in_ready are both high on a rising edge.
- **States:**
  - IDLE: first byte transfer latches mode and channel, then goes to LOAD or COLLECT.
  - LOAD: 16 bytes total, then IDLE.
  - COLLECT: 8 bytes total, then PRED.
  - PRED: 4 cycles, one MAC per cycle.
  - RECON: 1 cycle.
  - OUT: waits for out_ready; on handshake goes to PRED, or to IDLE after sample 19.
- in_ready is high only in IDLE, LOAD and COLLECT.
- **LMS record:**
  - Byte order: history[0..3], then weights[0..3], each an int16 MSB-first.
  - Weights are sign-extended to 32 bits on load.
- **Slice record:**
  - 64-bit word, big-endian.
  - sf = bits[63:60].
  - Residual k (k = 0..19) = bits[59-3k -: 3]; sample k uses residual k.
- **Dequantisation:** ROM of 16x8 entries, dq = round_half_away(S[sf] * M[r]).
  - S = {1,7,21,45,84,138,211,304,421,562,731,928,1157,1419,1715,2048}.
  - M = {0.75,-0.75,2.5,-2.5,4.5,-4.5,7,-7}.
  - Example: row sf=0 is {1,-1,3,-3,5,-5,7,-7}.
- **Prediction:**
  - acc = sum over i of (history[i] * weights[i]), each product truncated to 32 bits.
  - acc is 32-bit signed and wraps on overflow.
  - pred = acc >>> 13 (arithmetic shift).
- **Reconstruction:** s = clamp(pred + dq, -32768, 32767).
- **Update, applied on the OUT handshake:**
  - delta = dq >>> 4.
  - weights[i] += (history[i] < 0) ? -delta : delta; 32-bit, wrapping.
  - history shifts left by one: history[3] = s.
- **State storage:**
  - Per channel: 4 x int16 history and 4 x int32 weights.
  - Only the selected channel is read or modified.
- in_chan >= CHANNELS: the record's bytes are accepted and discarded, no state changes, no samples are produced.

## Timing
- **Reset values:** state IDLE, in_ready 1, out_valid 0, out_sample 0, out_chan 0, busy 0; all history and weights 0.
- **First-sample latency:** the last slice byte is accepted on edge E; PRED occupies E+1..E+4; RECON registers the output; out_valid rises on edge E+5.
- **Throughput:** with out_ready held high, one sample every 6 cycles; 20 samples per slice.
- **Output stability:** out_sample and out_chan hold stable while out_valid is high and out_ready is low.
- **out_valid deassertion:** after the handshake edge unless another sample is pending. The next out_valid rises 5 edges after the handshake.
- **First slice byte in IDLE:** the byte transfers in the same cycle it is presented; busy rises on that edge.
- **Reset mid-operation:** asserting rst_n low clears all state and outputs asynchronously, including LMS state. The partial record and any remaining samples are lost.
- **Back-to-back records:** in_ready is high from the cycle after the final OUT handshake; no other gap cycles.

## Test plan
- **Zero-state slice:** after reset, slice 0x0000000000000000 to channel 0 -> 20 samples, all +1, out_chan 0; weights unchanged, since delta is 0.
- **Max-scalefactor slice:** after reset, slice 0xF000000000000000 -> sample0 = 1536, sample1 = 1554 (weights all 96, pred 18). First out_valid exactly 5 edges after the 8th byte.
- **Clamp:** LMS load with history all 32767 and weights all 8192, then slice 0xF000000000000000 -> sample0 = 32767 (pred 131068 clamped). Also check a negative counterpart that clamps to -32768.
- **Backpressure:** hold out_ready low 10 cycles at sample 3 -> out_sample and out_valid stable, in_ready 0; release -> sample 4 valid 5 edges after the handshake.
- **Multi-channel (CHANNELS=2):** load channel 1 state, decode one slice on channel 0, then one on channel 1 -> channel 0 matches the zero-state model, channel 1 matches a model seeded with the loaded state, out_chan correct. A record with in_chan=3 at CHANNELS=2 produces no output.
- **Reset mid-slice:** assert rst_n low after sample 7 -> out_valid 0 and in_ready 1 immediately. After release, a zero slice yields twenty +1 samples, confirming the LMS state was cleared.
